// File: rtl/dac_lane_pusher_pkg.sv
// Shared types and default constants for the DAC lane pusher.
package radio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } pusherState_t;

  localparam int DEF_N_LANES = 8;
  localparam int DEF_IN_W    = 8;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_SHIFT   = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_PREFILL = 8;
  localparam int UNDERRUN_W  = 16;

endpackage

// File: rtl/dac_lane_pusher_if.sv
// Per-lane AXI-Stream sample input and shared DAC word output.
interface dac_lane_pusher_if import radio_pkg::*; #(
  parameter int N_LANES = DEF_N_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W
) ();

  logic [N_LANES-1:0][IN_W-1:0]  s_axis_inputI_tdata;
  logic [N_LANES-1:0][IN_W-1:0]  s_axis_inputQ_tdata;
  logic [N_LANES-1:0]            s_axis_input_tvalid;
  logic [N_LANES-1:0]            s_axis_input_tlast;
  logic [N_LANES-1:0]            s_axis_input_tready;

  logic [N_LANES-1:0][OUT_W-1:0] m_axis_outputDAI_tdata;
  logic [N_LANES-1:0][OUT_W-1:0] m_axis_outputDAQ_tdata;
  logic                          m_axis_output_tvalid;
  logic                          m_axis_output_tlast;
  logic                          m_axis_output_tready;

  // The pusher masters the DAC stream and accepts the lane samples.
  modport master (
    input  s_axis_inputI_tdata, s_axis_inputQ_tdata,
    input  s_axis_input_tvalid, s_axis_input_tlast,
    output s_axis_input_tready,
    output m_axis_outputDAI_tdata, m_axis_outputDAQ_tdata,
    output m_axis_output_tvalid, m_axis_output_tlast,
    input  m_axis_output_tready
  );

  modport slave (
    output s_axis_inputI_tdata, s_axis_inputQ_tdata,
    output s_axis_input_tvalid, s_axis_input_tlast,
    input  s_axis_input_tready,
    input  m_axis_outputDAI_tdata, m_axis_outputDAQ_tdata,
    input  m_axis_output_tvalid, m_axis_output_tlast,
    output m_axis_output_tready
  );

endinterface

// File: rtl/dac_lane_pusher_lane_fifo.sv
// Single-lane synchronous FIFO with occupancy output; push ignored when full, pop ignored when empty.
module lane_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic                       clk_250m,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic              doPush, doPop;

  assign full   = (level == LEVEL_W'(DEPTH));
  assign empty  = (level == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ADDR_W'(1);
      if (doPop)  rdPtr <= rdPtr + ADDR_W'(1);
      unique case ({doPush, doPop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by level, so stale entries are never read.
  always_ff @(posedge clk_250m) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/dac_lane_pusher.sv
// Buffers N_LANES of I/Q samples and pushes them lock-step to a DAC as sign-extended, shifted words.
module dac_lane_pusher import radio_pkg::*; #(
  parameter int N_LANES = DEF_N_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT   = DEF_SHIFT,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PREFILL = DEF_PREFILL
) (
  input  logic                  clk_250m,
  input  logic                  reset,
  input  logic                  enable,
  dac_lane_pusher_if.master     bus,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic                  misalign,
  output logic [1:0]            state
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 2 * IN_W + 1;

  logic [N_LANES-1:0]               laneFull, laneEmpty, lanePrefilled, laneLast;
  logic [N_LANES-1:0][LEVEL_W-1:0]  laneLevel;
  logic [N_LANES-1:0][ENTRY_W-1:0]  laneDout;
  logic [N_LANES-1:0][OUT_W-1:0]    outI, outQ;
  logic                             outValid, outLast;
  logic                             popAll, loadZero, loadOk, lastAccepted, allReady;
  logic [UNDERRUN_W-1:0]            underrunCnt;
  logic                             misalignFlag;
  pusherState_t                     curState, nextState;

  function automatic logic [OUT_W-1:0] toDac(input logic [IN_W-1:0] sample);
    logic signed [OUT_W-1:0] wide;
    wide = OUT_W'($signed(sample));
    return wide <<< SHIFT;
  endfunction

  for (genvar g = 0; g < N_LANES; g++) begin : gLane
    lane_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) uFifo (
      .clk_250m (clk_250m),
      .reset    (reset),
      .push     (bus.s_axis_input_tvalid[g]),
      .pop      (popAll),
      .din      ({bus.s_axis_input_tlast[g], bus.s_axis_inputQ_tdata[g], bus.s_axis_inputI_tdata[g]}),
      .dout     (laneDout[g]),
      .level    (laneLevel[g]),
      .full     (laneFull[g]),
      .empty    (laneEmpty[g])
    );
    assign bus.s_axis_input_tready[g] = ~laneFull[g];
    assign lanePrefilled[g]           = (laneLevel[g] >= LEVEL_W'(PREFILL));
    assign laneLast[g]                = laneDout[g][ENTRY_W-1];
  end

  assign allReady     = ~|laneEmpty;
  assign loadOk       = !outValid || bus.m_axis_output_tready;
  assign lastAccepted = outValid && outLast && bus.m_axis_output_tready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = curState;
    popAll    = 1'b0;
    loadZero  = 1'b0;
    unique case (curState)
      IDLE: if (enable) nextState = FILL;
      FILL: begin
        if (!enable)             nextState = IDLE;
        else if (&lanePrefilled) nextState = STREAM;
      end
      STREAM: begin
        if (!enable) nextState = DRAIN;
        if (loadOk) begin
          if (allReady) popAll = 1'b1;
          else begin
            loadZero  = 1'b1;
            nextState = FILL;
          end
        end
      end
      DRAIN: begin
        // The frame-closing word leaves first; nothing else is popped that cycle.
        if (lastAccepted) nextState = IDLE;
        else if (loadOk) begin
          if (allReady) popAll = 1'b1;
          else begin
            loadZero  = 1'b1;
            nextState = FILL;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      curState     <= IDLE;
      outValid     <= 1'b0;
      outLast      <= 1'b0;
      outI         <= '0;
      outQ         <= '0;
      underrunCnt  <= '0;
      misalignFlag <= 1'b0;
    end else begin
      curState <= nextState;
      if (popAll) begin
        outValid <= 1'b1;
        outLast  <= laneLast[0];
        for (int l = 0; l < N_LANES; l++) begin
          outI[l] <= toDac(laneDout[l][IN_W-1:0]);
          outQ[l] <= toDac(laneDout[l][2*IN_W-1:IN_W]);
        end
        if (laneLast != {N_LANES{laneLast[0]}}) misalignFlag <= 1'b1;
      end else if (loadZero) begin
        outValid <= 1'b1;
        outLast  <= 1'b0;
        outI     <= '0;
        outQ     <= '0;
        if (underrunCnt != '1) underrunCnt <= underrunCnt + UNDERRUN_W'(1);
      end else if (loadOk) begin
        // Pending word has been taken (or none was pending): go quiet.
        outValid <= 1'b0;
        outLast  <= 1'b0;
        outI     <= '0;
        outQ     <= '0;
      end
    end
  end

  assign bus.m_axis_outputDAI_tdata = outI;
  assign bus.m_axis_outputDAQ_tdata = outQ;
  assign bus.m_axis_output_tvalid   = outValid;
  assign bus.m_axis_output_tlast    = outLast;
  assign underrun_cnt               = underrunCnt;
  assign misalign                   = misalignFlag;
  assign state                      = curState;

endmodule

// File: tb/tb_dac_lane_pusher.sv
// Directed bench for dac_lane_pusher: default-parameter instance plus a 2-lane 12-bit instance.
module tb_dac_lane_pusher;
  import radio_pkg::*;

  localparam int NL  = 8;
  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int NL2 = 2;
  localparam int IW2 = 12;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic        reset, enable, reset2, enable2;
  logic [15:0] underrunCnt, underrunCnt2;
  logic        misalign, misalign2;
  logic [1:0]  stateOut, stateOut2;

  dac_lane_pusher_if #(.N_LANES(NL),  .IN_W(IW),  .OUT_W(OW)) bus ();
  dac_lane_pusher_if #(.N_LANES(NL2), .IN_W(IW2), .OUT_W(16)) bus2 ();

  dac_lane_pusher dut (
    .clk_250m(clk), .reset(reset), .enable(enable), .bus(bus),
    .underrun_cnt(underrunCnt), .misalign(misalign), .state(stateOut)
  );

  dac_lane_pusher #(.N_LANES(NL2), .IN_W(IW2), .OUT_W(16), .SHIFT(4), .DEPTH(16), .PREFILL(8)) dut2 (
    .clk_250m(clk), .reset(reset2), .enable(enable2), .bus(bus2),
    .underrun_cnt(underrunCnt2), .misalign(misalign2), .state(stateOut2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [NL-1:0][OW-1:0] dai;
    logic [NL-1:0][OW-1:0] daq;
    logic                  last;
  } word_t;

  typedef struct {
    logic [IW-1:0] inI;
    logic [IW-1:0] inQ;
    logic          last;
    logic [OW-1:0] expI;
    logic [OW-1:0] expQ;
  } vec_t;

  word_t capQ[$];

  // Records each word the DAC side will accept at the coming rising edge.
  always @(negedge clk) begin
    if (!reset && bus.m_axis_output_tvalid && bus.m_axis_output_tready)
      capQ.push_back('{dai: bus.m_axis_outputDAI_tdata, daq: bus.m_axis_outputDAQ_tdata,
                       last: bus.m_axis_output_tlast});
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] cvt8(input logic [IW-1:0] v);
    return {v, 8'h00};
  endfunction

  function automatic logic [NL*OW-1:0] rep(input logic [OW-1:0] v);
    logic [NL*OW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*OW +: OW] = v;
    return r;
  endfunction

  task automatic driveLane(input int l, input logic valid, input int w, input logic last);
    bus.s_axis_input_tvalid[l] = valid;
    bus.s_axis_inputI_tdata[l] = IW'(w);
    bus.s_axis_inputQ_tdata[l] = IW'(-w);
    bus.s_axis_input_tlast[l]  = last;
  endtask

  task automatic idleLanes();
    bus.s_axis_input_tvalid = '0;
    bus.s_axis_input_tlast  = '0;
  endtask

  task automatic pushAll(input logic [IW-1:0] iv, input logic [IW-1:0] qv, input logic last);
    for (int l = 0; l < NL; l++) begin
      bus.s_axis_inputI_tdata[l] = iv;
      bus.s_axis_inputQ_tdata[l] = qv;
    end
    bus.s_axis_input_tvalid = '1;
    bus.s_axis_input_tlast  = {NL{last}};
    tick();
    idleLanes();
  endtask

  task automatic doReset();
    reset                    = 1'b1;
    enable                   = 1'b0;
    bus.s_axis_inputI_tdata  = '0;
    bus.s_axis_inputQ_tdata  = '0;
    idleLanes();
    bus.m_axis_output_tready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    capQ.delete();
  endtask

  task automatic waitState(input pusherState_t s, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (stateOut != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, stateOut, s);
  endtask

  task automatic checkWord(input string tag, input int idx, input int w, input logic last);
    if (idx >= capQ.size()) begin
      checks++;
      failures++;
      $display("FAIL %s_%0d word missing: captured=%0d", tag, idx, capQ.size());
    end else begin
      check($sformatf("%s_%0d_dai", tag, idx), capQ[idx].dai, rep(cvt8(IW'(w))));
      check($sformatf("%s_%0d_daq", tag, idx), capQ[idx].daq, rep(cvt8(IW'(-w))));
      check($sformatf("%s_%0d_last", tag, idx), capQ[idx].last, last);
    end
  endtask

  // Reset state, then the conversion table streamed through one frame.
  task automatic testTable();
    vec_t tbl[8];
    tbl[0] = '{8'h01, 8'hFF, 1'b0, 16'h0100, 16'hFF00};
    tbl[1] = '{8'h02, 8'hFE, 1'b0, 16'h0200, 16'hFE00};
    tbl[2] = '{8'h7F, 8'h81, 1'b0, 16'h7F00, 16'h8100};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 16'h8000, 16'h8000};
    tbl[4] = '{8'hFF, 8'h01, 1'b0, 16'hFF00, 16'h0100};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{8'h55, 8'hAB, 1'b0, 16'h5500, 16'hAB00};
    tbl[7] = '{8'h08, 8'hF8, 1'b1, 16'h0800, 16'hF800};

    doReset();
    @(negedge clk);
    check("rst_state", stateOut, IDLE);
    check("rst_tvalid", bus.m_axis_output_tvalid, 1'b0);
    check("rst_tlast", bus.m_axis_output_tlast, 1'b0);
    check("rst_dai", bus.m_axis_outputDAI_tdata, '0);
    check("rst_daq", bus.m_axis_outputDAQ_tdata, '0);
    check("rst_tready", bus.s_axis_input_tready, {NL{1'b1}});
    check("rst_underrun", underrunCnt, 16'd0);
    check("rst_misalign", misalign, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) pushAll(tbl[i].inI, tbl[i].inQ, tbl[i].last);
    check("tbl_tready_lvl8", bus.s_axis_input_tready, {NL{1'b1}});
    enable = 1'b1;
    waitState(STREAM, 10, "tbl_reach_stream");
    check("tbl_no_word_before_pop", bus.m_axis_output_tvalid, 1'b0);
    tick();
    enable = 1'b0;
    @(negedge clk);
    check("tbl_latency1_valid", bus.m_axis_output_tvalid, 1'b1);
    waitState(IDLE, 30, "tbl_drain_idle");
    check("tbl_idle_tvalid", bus.m_axis_output_tvalid, 1'b0);
    tick();
    check("tbl_count", capQ.size(), 8);
    for (int i = 0; i < 8 && i < capQ.size(); i++) begin
      check($sformatf("tbl_%0d_dai", i), capQ[i].dai, rep(tbl[i].expI));
      check($sformatf("tbl_%0d_daq", i), capQ[i].daq, rep(tbl[i].expQ));
      check($sformatf("tbl_%0d_last", i), capQ[i].last, tbl[i].last);
    end
    check("tbl_underrun", underrunCnt, 16'd0);
  endtask

  // Lane 3 starves mid-stream: one zero word, back to FILL, resume once all lanes refill.
  task automatic testUnderrun();
    doReset();
    enable = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      for (int l = 0; l < NL; l++) driveLane(l, (l != 3) || (w <= 12), w, 1'b0);
      tick();
    end
    idleLanes();
    waitState(FILL, 30, "ur_to_fill");
    tick();
    check("ur_count1", underrunCnt, 16'd1);
    check("ur_captured", capQ.size(), 13);
    checkWord("ur_zero", 12, 0, 1'b0);
    check("ur_still_fill", stateOut, FILL);

    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < NL; l++) begin
        if (l == 3) driveLane(l, 1'b1, 13 + i, (13 + i) == 20);
        else        driveLane(l, i < 4, 17 + i, (17 + i) == 20);
      end
      tick();
    end
    idleLanes();
    waitState(STREAM, 10, "ur_resume");
    tick();
    enable = 1'b0;
    waitState(IDLE, 40, "ur_drain_idle");
    tick();
    check("ur_total", capQ.size(), 21);
    for (int i = 0; i < 21; i++) begin
      int w;
      w = (i < 12) ? i + 1 : (i == 12) ? 0 : i;
      checkWord("ur", i, w, w == 20);
    end
    check("ur_count_final", underrunCnt, 16'd1);
    check("ur_misalign", misalign, 1'b0);
  endtask

  // DAC stalls 5 cycles mid-stream: word held, FIFOs fill to DEPTH, tready drops.
  task automatic testBackpressure();
    int n;
    doReset();
    for (int w = 1; w <= 14; w++) pushAll(IW'(w), IW'(-w), 1'b0);
    check("bp_tready_lvl14", bus.s_axis_input_tready, {NL{1'b1}});
    enable = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.m_axis_output_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_valid", bus.m_axis_output_tvalid, 1'b1);
    tick();
    bus.m_axis_output_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) for (int l = 0; l < NL; l++) driveLane(l, 1'b1, 15 + i, (15 + i) == 18);
      else       idleLanes();
      @(negedge clk);
      check($sformatf("bp_hold%0d_dai", i), bus.m_axis_outputDAI_tdata, rep(16'h0200));
      check($sformatf("bp_hold%0d_valid", i), bus.m_axis_output_tvalid, 1'b1);
      tick();
    end
    idleLanes();
    check("bp_tready_full", bus.s_axis_input_tready, '0);
    bus.m_axis_output_tready = 1'b1;
    enable = 1'b0;
    waitState(IDLE, 40, "bp_drain_idle");
    tick();
    check("bp_total", capQ.size(), 18);
    for (int i = 0; i < 18; i++) checkWord("bp", i, i + 1, i == 17);
    check("bp_tready_back", bus.s_axis_input_tready, {NL{1'b1}});
  endtask

  // Lane 5 ends its frame one word early: sticky misalign until reset.
  task automatic testMisalign();
    doReset();
    for (int w = 1; w <= 8; w++) begin
      for (int l = 0; l < NL; l++) driveLane(l, 1'b1, w, (l == 5) ? (w == 7) : (w == 8));
      tick();
    end
    idleLanes();
    check("mis_before_pop", misalign, 1'b0);
    enable = 1'b1;
    waitState(STREAM, 10, "mis_stream");
    tick();
    enable = 1'b0;
    waitState(IDLE, 30, "mis_idle");
    tick();
    check("mis_set", misalign, 1'b1);
    check("mis_count", capQ.size(), 8);
    if (capQ.size() >= 8) begin
      check("mis_w7_last", capQ[6].last, 1'b0);
      check("mis_w8_last", capQ[7].last, 1'b1);
    end
    for (int i = 0; i < 6; i++) tick();
    check("mis_sticky", misalign, 1'b1);
    doReset();
    @(negedge clk);
    check("mis_cleared", misalign, 1'b0);
  endtask

  // 2-lane, 12-bit instance: -2048 maps to 0x8000, then reset mid-stream.
  task automatic testNarrow();
    int n;
    logic sawValid;
    reset2                    = 1'b1;
    enable2                   = 1'b0;
    bus2.s_axis_inputI_tdata  = '0;
    bus2.s_axis_inputQ_tdata  = '0;
    bus2.s_axis_input_tvalid  = '0;
    bus2.s_axis_input_tlast   = '0;
    bus2.m_axis_output_tready = 1'b1;
    tick();
    tick();
    reset2 = 1'b0;
    for (int w = 0; w < 10; w++) begin
      bus2.s_axis_inputI_tdata = {NL2{12'h800}};
      bus2.s_axis_inputQ_tdata = {NL2{12'h7FF}};
      bus2.s_axis_input_tvalid = '1;
      tick();
    end
    bus2.s_axis_input_tvalid = '0;
    enable2 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus2.m_axis_output_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nar_valid", bus2.m_axis_output_tvalid, 1'b1);
    check("nar_dai_min", bus2.m_axis_outputDAI_tdata, {16'h8000, 16'h8000});
    check("nar_daq_max", bus2.m_axis_outputDAQ_tdata, {16'h7FF0, 16'h7FF0});
    tick();
    reset2 = 1'b1;
    tick();
    @(negedge clk);
    check("nar_rst_valid", bus2.m_axis_output_tvalid, 1'b0);
    check("nar_rst_dai", bus2.m_axis_outputDAI_tdata, '0);
    check("nar_rst_daq", bus2.m_axis_outputDAQ_tdata, '0);
    check("nar_rst_last", bus2.m_axis_output_tlast, 1'b0);
    check("nar_rst_state", stateOut2, IDLE);
    tick();
    reset2 = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus2.m_axis_output_tvalid) sawValid = 1'b1;
    end
    check("nar_no_stale_word", sawValid, 1'b0);
    check("nar_fifo_empty", bus2.s_axis_input_tready, {NL2{1'b1}});
    check("nar_state_fill", stateOut2, FILL);
  endtask

  initial begin
    reset   = 1'b1;
    reset2  = 1'b1;
    enable  = 1'b0;
    enable2 = 1'b0;
    testTable();
    testUnderrun();
    testBackpressure();
    testMisalign();
    testNarrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_lane_pusher.md
DAC_LANE_PUSHER -- requirements
Module: dac_lane_pusher

Interface
REQ-001 SHALL have parameter N_LANES, default 8, number of I/Q lanes (1..16).
REQ-002 SHALL have parameter IN_W, default 8, input sample width (signed).
REQ-003 SHALL have parameter OUT_W, default 16, DAC sample width; OUT_W >= IN_W.
REQ-004 SHALL have parameter SHIFT, default 8, left shift after sign extension; SHIFT <= OUT_W-IN_W.
REQ-005 SHALL have parameter DEPTH, default 16, per-lane FIFO depth, power of 2, >= 4.
REQ-006 SHALL have parameter PREFILL, default 8, FIFO level all lanes need before streaming (1..DEPTH).
REQ-007 clk_250m  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  level; 1 requests streaming, 0 requests stop at next frame boundary.
REQ-010 s_axis_inputI_tdata / s_axis_inputQ_tdata  in  [N_LANES] x IN_W  per-lane I and Q sample.
REQ-011 s_axis_input_tvalid / s_axis_input_tlast  in  [N_LANES] x 1  per-lane valid and frame end.
REQ-012 s_axis_input_tready  out  [N_LANES] x 1  per-lane ready, equal to lane FIFO not full.
REQ-013 m_axis_outputDAI_tdata / m_axis_outputDAQ_tdata  out  [N_LANES] x OUT_W  DAC words.
REQ-014 m_axis_output_tvalid / m_axis_output_tlast  out  1 each  shared across all lanes.
REQ-015 m_axis_output_tready  in  1  shared DAC ready.
REQ-016 underrun_cnt  out  16  saturating count of underrun cycles.
REQ-017 misalign  out  1  sticky flag: lanes disagreed on tlast in one popped word.
REQ-018 state  out  2  current FSM state encoding.

Function
REQ-019 Each lane SHALL buffer {tlast, Q, I} in its own FIFO; push on tvalid && tready; tready = level < DEPTH.
REQ-020 Simultaneous push and pop on a lane SHALL leave its level unchanged; no push at full, no pop at empty.
REQ-021 FSM states SHALL be IDLE(0), FILL(1), STREAM(2), DRAIN(3).
REQ-022 IDLE: tvalid=0, data=0; enable=1 -> FILL.
REQ-023 FILL: no pops, tvalid=0; all lane levels >= PREFILL -> STREAM; enable=0 -> IDLE.
REQ-024 STREAM/DRAIN: when output register empty or m_axis_output_tready=1, all lanes non-empty -> pop all lanes in the same cycle and load output register.
REQ-025 Output register SHALL present popped data the cycle after the pop (latency 1 from pop); holds stable while tvalid=1 and tready=0.
REQ-026 Conversion: OUT = sign_extend(IN, OUT_W) << SHIFT, applied to I and Q independently; no saturation needed.
REQ-027 m_axis_output_tlast SHALL equal lane 0 popped tlast; any lane tlast differing from lane 0 sets misalign.
REQ-028 Underrun: in STREAM/DRAIN, load allowed but any lane empty -> pop nothing, load zero words with tvalid=1, tlast=0, underrun_cnt += 1 (saturate at 65535), state -> FILL.
REQ-029 STREAM with enable=0 -> DRAIN; DRAIN -> IDLE on the cycle a word with tlast=1 is accepted by the DAC.
REQ-030 enable returning to 1 in DRAIN SHALL be ignored until IDLE reached.
REQ-031 Transition to IDLE or FILL SHALL let any pending output word complete its handshake before tvalid drops.

Reset
REQ-032 reset SHALL empty all FIFOs, state=IDLE, all tdata=0, tvalid=0, tlast=0, tready=1 (from next cycle), underrun_cnt=0, misalign=0.
REQ-033 reset mid-frame SHALL discard all buffered samples; no partial word emitted after reset.

Structure
REQ-034 State enum and default parameter constants SHALL live in shared package radio_pkg.
REQ-035 Per-lane FIFO SHALL be one sub-module lane_fifo (DEPTH, width 2*IN_W+1, level output), instantiated N_LANES times.

Verification
REQ-036 Defaults; all lanes push 8 words (I=k, Q=-k) with tready=1 -> after level 8 STREAM, DAI=k<<8, DAQ=(-k)<<8 sign-extended, latency 1 per pop.
REQ-037 Lane 3 withholds data after 4 words while streaming -> one zero word, underrun_cnt=1, state=FILL, resumes when all levels >= 8.
REQ-038 m_axis_output_tready=0 for 5 cycles mid-stream -> output words held stable, no pops, lane FIFOs fill to 16, tready drops to 0.
REQ-039 enable=0 during 16-word frame (tlast on word 16) -> DRAIN, IDLE right after word 16 accepted, tvalid=0 next cycle.
REQ-040 Lane 5 tlast on word 7, others on word 8 -> misalign=1 and stays 1 until reset.
REQ-041 N_LANES=2, IN_W=12, OUT_W=16, SHIFT=4, input -2048 -> output 0x8000; reset asserted mid-stream -> all outputs 0 next cycle.
